// File: rtl/preset_seq_arbiter.sv
// preset_seq_arbiter: round-robin arbiter sharing one SETB preset sequencer
// between NREQ negative-edge preset flop banks. The sequence for a bank is:
// gate its clock, pulse SETB low, hold the clock through recovery, then
// restore the clock. All outputs come straight from flops so SETB and the
// clock enables never glitch.
module preset_seq_arbiter #(
    parameter int NREQ    = 4,
    parameter int PW_CYC  = 2,
    parameter int REC_CYC = 2,
    parameter int CW      = $clog2(((PW_CYC > REC_CYC) ? PW_CYC : REC_CYC) + 1)
) (
    input  logic            CLK,
    input  logic            RSTB,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] setb_o,
    output logic [NREQ-1:0] clken_o,
    output logic [NREQ-1:0] done,
    output logic            busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] PW_LOAD  = CW'(PW_CYC - 1);
    localparam logic [CW-1:0] REC_LOAD = CW'(REC_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ASSERT,
        RECOVER,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] setb_q, setb_d;
    logic [NREQ-1:0] clken_q, clken_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   j;
    logic [NREQ-1:0] sel;

    // Round-robin pick: first requesting bank at or above rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = IW'((int'(rr_q) + i) % NREQ);
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = j;
            end
        end
    end

    // Sequencer next state; outputs are decoded from the next state so they
    // can be registered alongside it without a cycle of lag.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = HALT;
                    idx_d   = pick;
                end
            end
            HALT: begin
                state_d = ASSERT;
                cnt_d   = PW_LOAD;
            end
            ASSERT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = RECOVER;
                    cnt_d   = REC_LOAD;
                end
            end
            RECOVER: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else             state_d = DONE;
            end
            DONE: begin
                // Requests dropped mid-sequence are ignored: a preset
                // cannot be aborted, so only here do we move on.
                state_d = IDLE;
                rr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        sel          = '0;
        sel[idx_d]   = 1'b1;
        gnt_d        = '0;
        setb_d       = '1;
        clken_d      = '1;
        done_d       = '0;
        case (state_d)
            HALT: begin
                gnt_d   = sel;
                clken_d = ~sel;
            end
            ASSERT: begin
                gnt_d   = sel;
                setb_d  = ~sel;
                clken_d = ~sel;
            end
            RECOVER: begin
                gnt_d   = sel;
                clken_d = ~sel;
            end
            DONE:    done_d = sel;
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset releases SETB and re-enables clocks.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            setb_q  <= '1;
            clken_q <= '1;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            setb_q  <= setb_d;
            clken_q <= clken_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign setb_o  = setb_q;
    assign clken_o = clken_q;
    assign done    = done_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_preset_seq_arbiter.sv
// Bench for preset_seq_arbiter: three instances (default 2/2, corner 1/1,
// corner 5/3), each driven by random bank owners. A timeline model predicts
// grant edges and bank order; a monitor checks grants, pulse widths, clock
// gating spans and done timing against it.
module tb_preset_seq_arbiter;
    localparam int N = 4;

    typedef struct {
        int bank;
        int k;
    } rec_t;

    logic CLK = 1'b0;
    logic RSTB;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   mode;
    logic [N-1:0] dir_req;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int PW  = (g == 0) ? 2 : (g == 1) ? 1 : 5;
        localparam int REC = (g == 0) ? 2 : (g == 1) ? 1 : 3;

        logic [N-1:0] req, gnt, setb, clken, done;
        logic         busy;
        rec_t         exp_q[$];

        preset_seq_arbiter #(.NREQ(N), .PW_CYC(PW), .REC_CYC(REC)) dut (
            .CLK(CLK), .RSTB(RSTB), .req(req), .gnt(gnt), .setb_o(setb),
            .clken_o(clken), .done(done), .busy(busy)
        );

        // Bank owners: hold req until done, sometimes drop mid-sequence.
        initial begin : stim
            req = '0;
            forever begin
                @(negedge CLK);
                case (mode)
                    1: for (int i = 0; i < N; i++) begin
                        if (!req[i]) begin
                            if ($urandom_range(3) == 0) req[i] = 1'b1;
                        end else if (done[i]) begin
                            if ($urandom_range(3) != 0) req[i] = 1'b0;
                        end else if (gnt[i] && $urandom_range(5) == 0) begin
                            req[i] = 1'b0;
                        end
                    end
                    2:       req = '1;
                    3:       req = dir_req;
                    default: req = '0;
                endcase
            end
        end

        // Timeline model: arbiter is free again PW+REC+3 edges after a grant.
        initial begin : model
            int rr, free, b;
            rr = 0;
            free = 0;
            forever begin
                @(posedge CLK or negedge RSTB);
                if (!RSTB) begin
                    rr = 0;
                    free = 0;
                    exp_q.delete();
                end else if (cyc >= free && req != '0) begin
                    b = -1;
                    for (int i = 0; i < N; i++)
                        if (b < 0 && req[(rr + i) % N]) b = (rr + i) % N;
                    exp_q.push_back('{bank: b, k: cyc});
                    free = cyc + PW + REC + 3;
                    rr = (b + 1) % N;
                end
            end
        end

        // Monitor: sampled on the falling edge, away from state changes.
        initial begin : mon
            logic [N-1:0] prev_gnt;
            int   setb_cnt [N];
            int   clk_cnt [N];
            int   e;
            rec_t r;
            string t;
            t = $sformatf("cfg%0d", g);
            prev_gnt = '0;
            for (int i = 0; i < N; i++) begin
                setb_cnt[i] = 0;
                clk_cnt[i] = 0;
            end
            forever begin
                @(negedge CLK);
                if (!RSTB) begin
                    prev_gnt = '0;
                    for (int i = 0; i < N; i++) begin
                        setb_cnt[i] = 0;
                        clk_cnt[i] = 0;
                    end
                end else begin
                    e = cyc - 1;
                    chk({t, " gnt_onehot"}, 32'($onehot0(gnt)), 32'(1));
                    chk({t, " idle_banks_high"},
                        32'(((setb | gnt | done) & (clken | gnt | done)) == '1), 32'(1));
                    chk({t, " busy"}, 32'(busy), 32'(gnt != '0 || done != '0));
                    for (int i = 0; i < N; i++) begin
                        if (!setb[i])  setb_cnt[i]++;
                        if (!clken[i]) clk_cnt[i]++;
                    end
                    if (gnt != '0 && prev_gnt == '0) begin
                        if (exp_q.size() == 0) begin
                            chk({t, " unexpected_grant"}, 32'(gnt), 32'(0));
                        end else begin
                            chk({t, " gnt_bank"}, 32'(gnt), 32'(1) << exp_q[0].bank);
                            chk({t, " gnt_edge"}, e, exp_q[0].k);
                        end
                    end
                    if (done != '0) begin
                        if (exp_q.size() == 0) begin
                            chk({t, " unexpected_done"}, 32'(done), 32'(0));
                        end else begin
                            r = exp_q.pop_front();
                            chk({t, " done_bank"}, 32'(done), 32'(1) << r.bank);
                            chk({t, " done_edge"}, e, r.k + 1 + PW + REC);
                            chk({t, " setb_width"}, setb_cnt[r.bank], PW);
                            chk({t, " clken_gap"}, clk_cnt[r.bank], PW + REC + 1);
                            chk({t, " clken_restored"}, 32'(clken[r.bank]), 32'(1));
                        end
                        for (int i = 0; i < N; i++) begin
                            setb_cnt[i] = 0;
                            clk_cnt[i] = 0;
                        end
                    end else if (exp_q.size() > 0 && e > exp_q[0].k + PW + REC + 3) begin
                        chk({t, " done_timeout"}, 32'(0), 32'(1));
                        void'(exp_q.pop_front());
                    end
                    prev_gnt = gnt;
                end
            end
        end
    end

    initial begin
        mode = 0;
        dir_req = '0;
        RSTB = 1'b1;
        #1 RSTB = 1'b0;
        #1;
        chk("reset gnt", 32'(cfg[0].gnt), 32'(0));
        chk("reset setb", 32'(cfg[0].setb), 32'hf);
        chk("reset clken", 32'(cfg[0].clken), 32'hf);
        chk("reset done", 32'(cfg[0].done), 32'(0));
        chk("reset busy", 32'(cfg[0].busy), 32'(0));
        repeat (3) @(negedge CLK);
        RSTB = 1'b1;

        // All banks requesting continuously: round-robin order 0,1,2,3,0...
        mode = 2;
        repeat (40) @(negedge CLK);
        mode = 0;
        repeat (20) @(negedge CLK);

        // Random owners with mid-sequence drops and re-requests.
        mode = 1;
        repeat (2000) @(negedge CLK);
        mode = 0;
        repeat (20) @(negedge CLK);

        // Reset while bank 1 is in ASSERT on the default instance.
        dir_req = 4'b0010;
        mode = 3;
        for (int i = 0; i < 20 && cfg[0].setb[1]; i++) @(negedge CLK);
        chk("reach_assert setb1", 32'(cfg[0].setb[1]), 32'(0));
        #2 RSTB = 1'b0;
        #1;
        chk("async_reset setb", 32'(cfg[0].setb), 32'hf);
        chk("async_reset clken", 32'(cfg[0].clken), 32'hf);
        chk("async_reset gnt", 32'(cfg[0].gnt), 32'(0));
        chk("async_reset busy", 32'(cfg[0].busy), 32'(0));
        @(negedge CLK);
        dir_req = 4'b0011;
        repeat (2) @(negedge CLK);
        RSTB = 1'b1;
        // rr restarts at 0: bank 0 first, then 1, then wrap past 2,3 to 0.
        repeat (40) @(negedge CLK);
        mode = 0;
        repeat (20) @(negedge CLK);

        chk("drained cfg0", cfg[0].exp_q.size(), 0);
        chk("drained cfg1", cfg[1].exp_q.size(), 0);
        chk("drained cfg2", cfg[2].exp_q.size(), 0);
        chk("idle busy cfg0", 32'(cfg[0].busy), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
